// File: rtl/axil_mem_tester_if.sv
// AXI-Lite bus bundle shared by the memory tester (master) and the slave bridge it drives.
// Both sides carry the five AXI-Lite channels; protection and strobes are carried but fixed by the master.
interface taxi_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport mst (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slv (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_mem_tester.sv
// AXI-Lite memory tester: writes an address or LFSR pattern over a word range, reads it back,
// and reports pass/fail, a saturating error count and the byte address of the first error.
module axil_mem_tester #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_WORDS  = 1024,
    parameter logic [31:0]           SEED       = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    taxi_axil_if.mst              axi_if,
    input  logic                  start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int                IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]       SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    if (DATA_WIDTH != 32) begin : g_chk_data_width
        $error("axil_mem_tester supports DATA_WIDTH = 32 only");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > (1 << 20)) begin : g_chk_num_words
        $error("axil_mem_tester NUM_WORDS must be in 1..2^20");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_base_align
        $error("axil_mem_tester BASE_ADDR must be 4-byte aligned");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [31:0]            lfsr;
    logic                   mode_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   bready_q;
    logic                   arvalid_q;
    logic                   rready_q;

    logic [31:0]            pattern;
    logic [31:0]            lfsr_next;
    logic                   last_word;
    logic                   aw_done;
    logic                   w_done;
    logic                   wr_err;
    logic                   rd_err;
    logic [15:0]            err_inc;

    // Address and pattern come straight from flops that only move between transactions,
    // which keeps them stable for as long as the matching valid is held.
    assign pattern   = mode_q ? lfsr : 32'(cur_addr);
    assign lfsr_next = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    assign last_word = (idx == LAST_IDX);
    assign aw_done   = !awvalid_q || axi_if.awready;
    assign w_done    = !wvalid_q || axi_if.wready;
    assign wr_err    = (axi_if.bresp != 2'b00);
    assign rd_err    = (32'(axi_if.rdata) != pattern) || (axi_if.rresp != 2'b00);
    assign err_inc   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    assign axi_if.awaddr  = cur_addr;
    assign axi_if.awprot  = 3'b000;
    assign axi_if.awvalid = awvalid_q;
    assign axi_if.wdata   = pattern;
    assign axi_if.wstrb   = '1;
    assign axi_if.wvalid  = wvalid_q;
    assign axi_if.bready  = bready_q;
    assign axi_if.araddr  = cur_addr;
    assign axi_if.arprot  = 3'b000;
    assign axi_if.arvalid = arvalid_q;
    assign axi_if.rready  = rready_q;

    // NOTE: the bus valids/readies are ordinary flops on the async reset, so pulling rst_n low
    // drops them at once without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            cur_addr       <= BASE_ADDR;
            lfsr           <= SEED_EFF;
            mode_q         <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            // NOTE: every flop here uses <= so each branch reads pre-edge values of the whole FSM.
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_WR_REQ;
                        idx            <= '0;
                        cur_addr       <= BASE_ADDR;
                        lfsr           <= SEED_EFF;
                        mode_q         <= mode;
                        awvalid_q      <= 1'b1;
                        wvalid_q       <= 1'b1;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                    end
                end

                S_WR_REQ: begin
                    if (awvalid_q && axi_if.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi_if.wready) wvalid_q <= 1'b0;
                    if (aw_done && w_done) begin
                        state    <= S_WR_RESP;
                        bready_q <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (axi_if.bvalid) begin
                        bready_q <= 1'b0;
                        if (wr_err) begin
                            err_count <= err_inc;
                            if (err_count == 16'd0) first_err_addr <= cur_addr;
                        end
                        if (last_word) begin
                            state     <= S_RD_REQ;
                            idx       <= '0;
                            cur_addr  <= BASE_ADDR;
                            lfsr      <= SEED_EFF;
                            arvalid_q <= 1'b1;
                        end else begin
                            state     <= S_WR_REQ;
                            idx       <= idx + IDX_W'(1);
                            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
                            lfsr      <= lfsr_next;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (axi_if.arready) begin
                        state     <= S_RD_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end

                S_RD_DATA: begin
                    if (axi_if.rvalid) begin
                        rready_q <= 1'b0;
                        if (rd_err) begin
                            err_count <= err_inc;
                            if (err_count == 16'd0) first_err_addr <= cur_addr;
                        end
                        if (last_word) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 16'd0) && !rd_err;
                        end else begin
                            state     <= S_RD_REQ;
                            idx       <= idx + IDX_W'(1);
                            cur_addr  <= cur_addr + ADDR_WIDTH'(4);
                            lfsr      <= lfsr_next;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_mem_tester.sv
// Self-checking bench for axil_mem_tester: a behavioural AXI-Lite RAM with optional random back-pressure
// and fault injection, plus a reference model that derives expected traffic and results per run.
`timescale 1ns/1ps
module tb_axil_mem_tester;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    int n_checks = 0;
    int n_pass = 0;

    taxi_axil_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axil_mem_tester #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BASE_ADDR (BASE),
        .NUM_WORDS (NW),
        .SEED      (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axi_if        (axi),
        .start         (start),
        .mode          (mode),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- slave RAM model with knobs ----------------
    bit              bp_en = 1'b0;
    logic [NW-1:0]   corrupt_mask = '0;
    logic [NW-1:0]   bresp_mask = '0;
    logic [NW-1:0]   rresp_mask = '0;

    logic [31:0] mem [NW];
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
    logic        aw_rnd, w_rnd, ar_rnd;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] rd_addr_log[$];
    bit          rd_seen = 1'b0;
    int          order_err = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) & 32'(NW - 1));
    endfunction

    assign axi.awready = aw_rnd && !aw_got;
    assign axi.wready  = w_rnd && !w_got;
    assign axi.arready = ar_rnd && !ar_got && !axi.rvalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            ar_got     <= 1'b0;
            aw_rnd     <= 1'b0;
            w_rnd      <= 1'b0;
            ar_rnd     <= 1'b0;
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            axi.rresp  <= 2'b00;
        end else begin
            aw_rnd <= bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            w_rnd  <= bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            ar_rnd <= bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (axi.awvalid && axi.awready) begin
                aw_got    <= 1'b1;
                aw_addr_l <= axi.awaddr;
                wr_addr_log.push_back(axi.awaddr);
                if (rd_seen) order_err <= order_err + 1;
            end
            if (axi.wvalid && axi.wready) begin
                w_got    <= 1'b1;
                w_data_l <= axi.wdata;
                wr_data_log.push_back(axi.wdata);
            end
            if (aw_got && w_got && !axi.bvalid && (!bp_en || $urandom_range(0, 3) != 0)) begin
                mem[widx(aw_addr_l)] <= w_data_l;
                axi.bvalid <= 1'b1;
                axi.bresp  <= bresp_mask[widx(aw_addr_l)] ? 2'b10 : 2'b00;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                ar_got    <= 1'b1;
                ar_addr_l <= axi.araddr;
                rd_addr_log.push_back(axi.araddr);
                rd_seen   <= 1'b1;
            end
            if (ar_got && !axi.rvalid && (!bp_en || $urandom_range(0, 3) != 0)) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= mem[widx(ar_addr_l)] ^ {31'b0, corrupt_mask[widx(ar_addr_l)]};
                axi.rresp  <= rresp_mask[widx(ar_addr_l)] ? 2'b10 : 2'b00;
                ar_got     <= 1'b0;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // Valid-hold monitor: a pending valid must stay up with unchanged payload until its handshake.
    logic        pend_aw, pend_w, pend_ar;
    logic [31:0] hold_aw, hold_w, hold_ar;
    int          viol = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_aw <= 1'b0;
            pend_w  <= 1'b0;
            pend_ar <= 1'b0;
        end else begin
            viol <= viol
                + int'(pend_aw && (!axi.awvalid || axi.awaddr != hold_aw))
                + int'(pend_w  && (!axi.wvalid  || axi.wdata  != hold_w))
                + int'(pend_ar && (!axi.arvalid || axi.araddr != hold_ar));
            pend_aw <= axi.awvalid && !axi.awready;
            pend_w  <= axi.wvalid && !axi.wready;
            pend_ar <= axi.arvalid && !axi.arready;
            hold_aw <= axi.awaddr;
            hold_w  <= axi.wdata;
            hold_ar <= axi.araddr;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [31:0] expect_word(input bit m, input int i);
        logic [31:0] l;
        l = (SEED == 32'h0) ? 32'h1 : SEED;
        if (!m) return BASE + 32'(4 * i);
        for (int k = 0; k < i; k++) l = lfsr_step(l);
        return l;
    endfunction

    task automatic arm(input bit bp, input logic [NW-1:0] cm, input logic [NW-1:0] bm,
                       input logic [NW-1:0] rm);
        @(negedge clk);
        bp_en = bp;
        corrupt_mask = cm;
        bresp_mask = bm;
        rresp_mask = rm;
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        rd_seen = 1'b0;
        order_err = 0;
        viol = 0;
    endtask

    task automatic run_test(input string name, input bit m, input bit bp, input logic [NW-1:0] cm,
                            input logic [NW-1:0] bm, input logic [NW-1:0] rm, input bit poke);
        int          exp_err;
        logic [31:0] exp_first;
        int          cyc;
        int          n;
        arm(bp, cm, bm, rm);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        check({name, "/awvalid_after_start"}, 32'(axi.awvalid), 32'd1);
        check({name, "/wvalid_after_start"}, 32'(axi.wvalid), 32'd1);
        check({name, "/busy_after_start"}, 32'(busy), 32'd1);
        check({name, "/done_cleared"}, 32'(done), 32'd0);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 7) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
        check({name, "/done_in_time"}, 32'(done), 32'd1);

        exp_err = 0;
        exp_first = '0;
        for (int i = 0; i < NW; i++) begin
            if (bm[i]) begin
                if (exp_err == 0) exp_first = BASE + 32'(4 * i);
                exp_err++;
            end
        end
        for (int i = 0; i < NW; i++) begin
            if (cm[i] || rm[i]) begin
                if (exp_err == 0) exp_first = BASE + 32'(4 * i);
                exp_err++;
            end
        end
        check({name, "/err_count"}, 32'(err_count), 32'(exp_err));
        check({name, "/first_err_addr"}, first_err_addr, exp_first);
        check({name, "/pass"}, 32'(pass), 32'(exp_err == 0));
        check({name, "/busy_done"}, 32'(busy), 32'd0);
        check({name, "/n_writes"}, 32'(wr_addr_log.size()), 32'(NW));
        check({name, "/n_reads"}, 32'(rd_addr_log.size()), 32'(NW));
        check({name, "/wr_before_rd"}, 32'(order_err), 32'd0);
        check({name, "/valid_hold"}, 32'(viol), 32'd0);
        n = (wr_addr_log.size() < NW) ? wr_addr_log.size() : NW;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s/wr_addr[%0d]", name, i), wr_addr_log[i], BASE + 32'(4 * i));
            check($sformatf("%s/wr_data[%0d]", name, i), wr_data_log[i], expect_word(m, i));
        end
        n = (rd_addr_log.size() < NW) ? rd_addr_log.size() : NW;
        for (int i = 0; i < n; i++)
            check($sformatf("%s/rd_addr[%0d]", name, i), rd_addr_log[i], BASE + 32'(4 * i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("reset/awvalid", 32'(axi.awvalid), 32'd0);
        check("reset/wvalid", 32'(axi.wvalid), 32'd0);
        check("reset/arvalid", 32'(axi.arvalid), 32'd0);
        check("reset/bready", 32'(axi.bready), 32'd0);
        check("reset/rready", 32'(axi.rready), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/pass", 32'(pass), 32'd0);
        check("reset/err_count", 32'(err_count), 32'd0);
        check("reset/first_err_addr", first_err_addr, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test("addr0", 1'b0, 1'b0, '0, '0, '0, 1'b0);
        if (wr_addr_log.size() > 5) begin
            check("addr0/word5_addr", wr_addr_log[5], 32'h14);
            check("addr0/word5_data", wr_data_log[5], 32'h14);
        end
        run_test("lfsr0", 1'b1, 1'b0, '0, '0, '0, 1'b0);
        if (wr_data_log.size() > 1) begin
            check("lfsr0/word0", wr_data_log[0], 32'h1);
            check("lfsr0/word1", wr_data_log[1], 32'h3);
        end
        run_test("corrupt_7_9", 1'b0, 1'b0, 16'h0280, '0, '0, 1'b0);
        run_test("bp_addr", 1'b0, 1'b1, '0, '0, '0, 1'b1);
        run_test("bp_lfsr", 1'b1, 1'b1, '0, '0, '0, 1'b1);
        run_test("slverr_w3", 1'b0, 1'b0, '0, 16'h0008, '0, 1'b0);
        run_test("rresp_last", 1'b1, 1'b1, '0, '0, 16'h8000, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_test($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b1,
                     NW'($urandom) & NW'($urandom) & NW'($urandom),
                     NW'($urandom) & NW'($urandom) & NW'($urandom),
                     NW'($urandom) & NW'($urandom) & NW'($urandom), 1'b0);
        end

        // Reset while a read is in flight, after one error has been logged.
        arm(1'b0, 16'h0001, '0, '0);
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(axi.rready && rd_addr_log.size() > 5) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid/reached_rd_data", 32'(axi.rready), 32'd1);
        check("rst_mid/err_before_reset", 32'(err_count), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid/awvalid", 32'(axi.awvalid), 32'd0);
        check("rst_mid/wvalid", 32'(axi.wvalid), 32'd0);
        check("rst_mid/arvalid", 32'(axi.arvalid), 32'd0);
        check("rst_mid/bready", 32'(axi.bready), 32'd0);
        check("rst_mid/rready", 32'(axi.rready), 32'd0);
        check("rst_mid/busy", 32'(busy), 32'd0);
        check("rst_mid/done", 32'(done), 32'd0);
        check("rst_mid/pass", 32'(pass), 32'd0);
        check("rst_mid/err_count", 32'(err_count), 32'd0);
        check("rst_mid/first_err_addr", first_err_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_test("after_reset", 1'b0, 1'b0, '0, '0, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
